regfile_write_sched: RTL and testbench
======================================

REGFILE_WRITE_SCHED -- requirements
Module: regfile_write_sched

Interface
REQ-001 Parameter: PEND_DEPTH, default 2, number of buffered R0 write entries (legal 1..4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 wb_valid  input  1  pipeline write-back request.
REQ-005 wb_reg  input  4  write-back destination register.
REQ-006 wb_data  input  16  write-back data.
REQ-007 r0_valid  input  1  mul/div R0 (upper half / remainder) write request.
REQ-008 r0_data  input  16  R0 write data.
REQ-009 rf_we  output  1  register-file write enable, registered.
REQ-010 rf_waddr  output  4  register-file write address, registered.
REQ-011 rf_wdata  output  16  register-file write data, registered.
REQ-012 stall  output  1  R0 buffer full; requester holds r0_valid low, registered.
REQ-013 pend_cnt  output  3  R0 entries pending, registered.
REQ-014 overflow  output  1  sticky: r0 request dropped.
REQ-015 r0_fwd_valid  output  1  pending R0 value exists (forwarding).
REQ-016 r0_fwd_data  output  16  newest pending R0 value.

Function
REQ-017 The block shall sequence two writers onto the register file's single write port; each accepted request shall appear on rf_we/rf_waddr/rf_wdata exactly one cycle later, or later if buffered.
REQ-018 wb_valid shall have absolute priority: a wb_valid cycle always produces rf_we=1, rf_waddr=wb_reg, rf_wdata=wb_data next cycle, with no stall.
REQ-019 r0_valid with wb_valid=0 and buffer empty shall bypass: next cycle rf_we=1, rf_waddr=0, rf_wdata=r0_data.
REQ-020 r0_valid with wb_valid=1, or with buffer non-empty, shall enqueue r0_data at buffer tail (FIFO order).
REQ-021 Cycle with wb_valid=0 and buffer non-empty shall dequeue head to the write port next cycle; a same-cycle r0_valid shall enqueue behind it (simultaneous push/pop, count unchanged).
REQ-022 FSM states: IDLE (count 0), DRAIN (0<count<PEND_DEPTH), FULL (count=PEND_DEPTH); transitions follow count after each push/pop/flush.
REQ-023 stall shall equal (state==FULL); r0_valid in FULL with wb_valid=1 shall be dropped and set overflow; with wb_valid=0 the pop frees a slot and the push is accepted.
REQ-024 wb_valid with wb_reg=0 shall flush all pending entries (older than the wb write) in the same cycle; a same-cycle r0_valid is treated as newer and enqueued into the flushed buffer.
REQ-025 pend_cnt shall never exceed PEND_DEPTH nor underflow; read/write pointers wrap modulo PEND_DEPTH.
REQ-026 rf_we shall be 0 in any cycle following one with no wb_valid, no r0_valid, and empty buffer.

Reset
REQ-027 On reset: buffer emptied, state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, pend_cnt=0, overflow=0, r0_fwd_valid=0, r0_fwd_data=0.
REQ-028 Reset asserted mid-operation shall discard pending entries and any in-flight write; requests in the reset cycle are ignored.

Configuration
REQ-029 Macro REGFILE_R0_FWD_EN defined: r0_fwd_valid=(pend_cnt!=0), r0_fwd_data=most recently enqueued entry, combinational from registered state.
REQ-030 Macro REGFILE_R0_FWD_EN undefined: r0_fwd_valid and r0_fwd_data tied to 0; all other behaviour identical.

Verification
REQ-031 wb_valid=1, wb_reg=5, wb_data=7B18 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=7B18.
REQ-032 wb_valid=1 (reg 3, FFFF) and r0_valid=1 (0051) same cycle, then idle -> cycle+1 writes R3=FFFF, cycle+2 writes R0=0051, pend_cnt 1 then 0.
REQ-033 Three consecutive cycles wb_valid=1 with r0_valid=1 (data 0001,0002,0003), PEND_DEPTH=2 -> stall=1 after second, third dropped, overflow=1, later drain writes R0=0001 then 0002.
REQ-034 Buffer holds 00FF; wb_valid=1, wb_reg=0, wb_data=CCCC -> pending flushed, next cycle R0=CCCC, no later R0 write.
REQ-035 Buffer holds two entries; reset pulsed one cycle -> pend_cnt=0, rf_we=0 thereafter, overflow cleared.
REQ-036 With REGFILE_R0_FWD_EN: enqueue 245B then 6666 -> r0_fwd_valid=1, r0_fwd_data=6666; without macro both remain 0.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Arbitrates pipeline write-back and buffered mul/div R0 writes onto one register-file write port.
// Optional R0 forwarding of the newest pending entry is enabled by defining REGFILE_R0_FWD_EN.
module regfile_write_sched #(
  parameter int PEND_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        r0_valid,
  input  logic [15:0] r0_data,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        stall,
  output logic [2:0]  pend_cnt,
  output logic        overflow,
  output logic        r0_fwd_valid,
  output logic [15:0] r0_fwd_data,
  output logic [1:0]  dbg_state
);

  // Handshake: wb_valid is always accepted. r0_valid is accepted unless stall is high
  // and wb_valid is high in the same cycle; such a request is dropped and flags overflow.
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FULL = 2'd2} state_e;

  localparam logic [1:0] LAST    = 2'(PEND_DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(PEND_DEPTH);

  state_e      state_q, state_d;
  logic [15:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        overflow_q, overflow_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_waddr_q, rf_waddr_d;
  logic [15:0] rf_wdata_q, rf_wdata_d;
  logic        flush, pop, bypass, drop, push;
  logic [1:0]  rd_base;
  logic [2:0]  cnt_base;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    flush  = wb_valid && (wb_reg == 4'd0);
    pop    = !wb_valid && (cnt_q != 3'd0);
    bypass = r0_valid && !wb_valid && (cnt_q == 3'd0);
    drop   = r0_valid && wb_valid && !flush && (cnt_q == DEPTH_C);
    push   = r0_valid && !bypass && !drop;

    // A flush discards everything older than the wb write; a same-cycle push lands behind it.
    rd_base  = flush ? wr_ptr_q : rd_ptr_q;
    cnt_base = flush ? 3'd0 : cnt_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_base;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_base + {2'b00, push} - {2'b00, pop};
    overflow_d = overflow_q || drop;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_reg;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = 4'd0;
      rf_wdata_d = mem_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = 4'd0;
      rf_wdata_d = r0_data;
    end
  end

  always_comb begin
    state_d = DRAIN;
    if (cnt_d == 3'd0)         state_d = IDLE;
    else if (cnt_d == DEPTH_C) state_d = FULL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
      overflow_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'd0;
      rf_wdata_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= r0_data;
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall     = (state_q == FULL);
  assign pend_cnt  = cnt_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

`ifdef REGFILE_R0_FWD_EN
  logic [1:0] newest;
  assign newest       = (wr_ptr_q == 2'd0) ? LAST : wr_ptr_q - 2'd1;
  assign r0_fwd_valid = (cnt_q != 3'd0);
  assign r0_fwd_data  = (cnt_q != 3'd0) ? mem_q[newest] : 16'd0;
`else
  assign r0_fwd_valid = 1'b0;
  assign r0_fwd_data  = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: queue-based model checked every cycle plus literal checks.
module tb_regfile_write_sched;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, r0_valid = 1'b0;
  logic [3:0]  wb_reg = 4'd0;
  logic [15:0] wb_data = 16'd0, r0_data = 16'd0;
  logic        rf_we, stall, overflow, r0_fwd_valid;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, r0_fwd_data;
  logic [2:0]  pend_cnt;
  logic [1:0]  dbg_state;

  regfile_write_sched #(.PEND_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .r0_valid(r0_valid), .r0_data(r0_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall(stall), .pend_cnt(pend_cnt), .overflow(overflow),
    .r0_fwd_valid(r0_fwd_valid), .r0_fwd_data(r0_fwd_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending R0 values as a plain queue, plus the write expected on the port.
  logic [15:0] exp_q[$];
  logic        exp_we = 1'b0;
  logic [3:0]  exp_addr = 4'd0;
  logic [15:0] exp_data = 16'd0;
  logic        exp_ovf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_we <= 1'b0; exp_addr <= 4'd0; exp_data <= 16'd0; exp_ovf <= 1'b0;
    end else begin
      exp_we <= 1'b0;
      if (wb_valid) begin
        exp_we <= 1'b1; exp_addr <= wb_reg; exp_data <= wb_data;
        if (wb_reg == 4'd0) exp_q.delete();
        if (r0_valid) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(r0_data);
          else exp_ovf <= 1'b1;
        end
      end else if (exp_q.size() > 0) begin
        exp_we <= 1'b1; exp_addr <= 4'd0; exp_data <= exp_q.pop_front();
        if (r0_valid) exp_q.push_back(r0_data);
      end else if (r0_valid) begin
        exp_we <= 1'b1; exp_addr <= 4'd0; exp_data <= r0_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rf_we", {15'd0, rf_we}, {15'd0, exp_we});
      if (exp_we) begin
        check("rf_waddr", {12'd0, rf_waddr}, {12'd0, exp_addr});
        check("rf_wdata", rf_wdata, exp_data);
      end
      check("pend_cnt", {13'd0, pend_cnt}, 16'(exp_q.size()));
      check("stall", {15'd0, stall}, {15'd0, exp_q.size() == DEPTH});
      check("overflow", {15'd0, overflow}, {15'd0, exp_ovf});
`ifdef REGFILE_R0_FWD_EN
      check("fwd_valid", {15'd0, r0_fwd_valid}, {15'd0, exp_q.size() != 0});
      check("fwd_data", r0_fwd_data, (exp_q.size() != 0) ? exp_q[$] : 16'd0);
`else
      check("fwd_valid", {15'd0, r0_fwd_valid}, 16'd0);
      check("fwd_data", r0_fwd_data, 16'd0);
`endif
    end
  end

  task automatic step(input logic wv, input logic [3:0] wr, input logic [15:0] wd,
                      input logic rv, input logic [15:0] rd);
    wb_valid = wv; wb_reg = wr; wb_data = wd; r0_valid = rv; r0_data = rd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'd0, 1'b0, 16'd0);
  endtask

  // Literal write check: we, addr, data observed right after the edge.
  task automatic lit_wr(input string name, input logic [3:0] a, input logic [15:0] d);
    check({name, "_we"}, {15'd0, rf_we}, 16'd1);
    check({name, "_addr"}, {12'd0, rf_waddr}, {12'd0, a});
    check({name, "_data"}, rf_wdata, d);
  endtask

  initial begin
    reset = 1'b1;
    idle(); chk_en = 1'b1; idle();
    reset = 1'b0;
    check("rst_we", {15'd0, rf_we}, 16'd0);
    check("rst_waddr", {12'd0, rf_waddr}, 16'd0);
    check("rst_wdata", rf_wdata, 16'd0);
    check("rst_pend", {13'd0, pend_cnt}, 16'd0);
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);
    check("rst_fwd", {r0_fwd_valid, r0_fwd_data[14:0]}, 16'd0);

    // Plain write-back
    step(1'b1, 4'd5, 16'h7B18, 1'b0, 16'd0);
    lit_wr("wb5", 4'd5, 16'h7B18);

    // Write-back and R0 collide; R0 follows one cycle later
    step(1'b1, 4'd3, 16'hFFFF, 1'b1, 16'h0051);
    lit_wr("col_r3", 4'd3, 16'hFFFF);
    check("col_pend1", {13'd0, pend_cnt}, 16'd1);
    idle();
    lit_wr("col_r0", 4'd0, 16'h0051);
    check("col_pend0", {13'd0, pend_cnt}, 16'd0);
    idle();
    check("idle_we", {15'd0, rf_we}, 16'd0);

    // Bypass path
    step(1'b0, 4'd0, 16'd0, 1'b1, 16'h1234);
    lit_wr("bypass", 4'd0, 16'h1234);

    // Simultaneous push/pop keeps the count
    step(1'b1, 4'd7, 16'h0707, 1'b1, 16'hAAAA);
    step(1'b0, 4'd0, 16'd0, 1'b1, 16'hBBBB);
    lit_wr("pp_head", 4'd0, 16'hAAAA);
    check("pp_pend", {13'd0, pend_cnt}, 16'd1);
    idle();
    lit_wr("pp_tail", 4'd0, 16'hBBBB);

    // Full with no write-back: pop frees a slot, push accepted
    step(1'b1, 4'd1, 16'h0001, 1'b1, 16'h0A01);
    step(1'b1, 4'd2, 16'h0002, 1'b1, 16'h0A02);
    check("full_stall", {15'd0, stall}, 16'd1);
    step(1'b0, 4'd0, 16'd0, 1'b1, 16'h0A03);
    lit_wr("full_pop", 4'd0, 16'h0A01);
    check("full_pend", {13'd0, pend_cnt}, 16'd2);
    check("full_noovf", {15'd0, overflow}, 16'd0);
    idle(); idle(); idle();

    // Flush via write to R0
    step(1'b1, 4'd1, 16'h0101, 1'b1, 16'h00FF);
    step(1'b1, 4'd0, 16'hCCCC, 1'b0, 16'd0);
    lit_wr("flush", 4'd0, 16'hCCCC);
    check("flush_pend", {13'd0, pend_cnt}, 16'd0);
    idle();
    check("flush_noR0", {15'd0, rf_we}, 16'd0);

    // Overflow on third collision
    step(1'b1, 4'd1, 16'h1111, 1'b1, 16'h0001);
    step(1'b1, 4'd2, 16'h2222, 1'b1, 16'h0002);
    check("ovf_stall", {15'd0, stall}, 16'd1);
    step(1'b1, 4'd4, 16'h4444, 1'b1, 16'h0003);
    check("ovf_flag", {15'd0, overflow}, 16'd1);
    idle();
    lit_wr("ovf_d1", 4'd0, 16'h0001);
    idle();
    lit_wr("ovf_d2", 4'd0, 16'h0002);
    idle();
    check("ovf_done", {15'd0, rf_we}, 16'd0);

    // Forwarding, then reset mid-operation
    step(1'b1, 4'd6, 16'h6060, 1'b1, 16'h245B);
    step(1'b1, 4'd8, 16'h8080, 1'b1, 16'h6666);
`ifdef REGFILE_R0_FWD_EN
    check("fwd_v", {15'd0, r0_fwd_valid}, 16'd1);
    check("fwd_d", r0_fwd_data, 16'h6666);
`else
    check("fwd_v", {15'd0, r0_fwd_valid}, 16'd0);
    check("fwd_d", r0_fwd_data, 16'd0);
`endif
    reset = 1'b1;
    step(1'b1, 4'd9, 16'h9999, 1'b1, 16'h7777);
    reset = 1'b0;
    check("mrst_pend", {13'd0, pend_cnt}, 16'd0);
    check("mrst_ovf", {15'd0, overflow}, 16'd0);
    check("mrst_we", {15'd0, rf_we}, 16'd0);
    idle();
    check("mrst_we2", {15'd0, rf_we}, 16'd0);

    // Flush while full with a newer R0 request
    step(1'b1, 4'd1, 16'h0B0B, 1'b1, 16'h0B01);
    step(1'b1, 4'd2, 16'h0B0B, 1'b1, 16'h0B02);
    step(1'b1, 4'd0, 16'hDDDD, 1'b1, 16'h0B03);
    lit_wr("ffl", 4'd0, 16'hDDDD);
    check("ffl_pend", {13'd0, pend_cnt}, 16'd1);
    check("ffl_ovf", {15'd0, overflow}, 16'd0);
    idle();
    lit_wr("ffl_new", 4'd0, 16'h0B03);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom_range(0, 1)), 16'($urandom));
    end
    reset = 1'b0;
    idle(); idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
